// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I
// multicycle sequencing controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    LUI,
    AUIPC,
    WB_ALU,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JAL,
    TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_RS1   = 2'b01;
  localparam logic [1:0] A_OLDPC = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_FOUR = 2'b01;
  localparam logic [1:0] B_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic branch_ok(
    input logic [2:0] f3
  );
    return f3[2:1] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request
// is left waiting; flags the last allowed one.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIMIT =
    W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // wait counter, restarts whenever not waiting
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = count && (cnt == LIMIT);

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I controller: sequences the
// shared-memory datapath through FETCH..WB.
module control_multiciclo
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_source,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  state_t state, nxt;
  logic   waiting;
  logic   stalled;
  logic   expired;
  logic   trap_ill;
  logic   trap_to;
  logic   retire;

  assign stalled = waiting && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .clear  (!stalled),
    .count  (stalled),
    .expired(expired)
  );

  // state, sticky trap flags, retire counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= FETCH;
      illegal <= 1'b0;
      timeout <= 1'b0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (trap_ill) illegal <= 1'b1;
      if (trap_to)  timeout <= 1'b1;
      if (retire)   retired <= retired + 1'b1;
    end
  end

  // next state and Moore/Mealy control decode
  always_comb begin
    nxt        = state;
    waiting    = 1'b0;
    trap_ill   = 1'b0;
    trap_to    = 1'b0;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = M2R_ALU;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_op     = ALU_ADD;
    pc_source  = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = A_PC;
        alu_src_b = B_FOUR;
        waiting   = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end else if (expired) begin
          trap_to = 1'b1;
          nxt     = TRAP;
        end
      end
      DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        unique case (1'b1)
          opcode == OP_R:
            nxt = EXEC_R;
          opcode == OP_I:
            nxt = EXEC_I;
          opcode == OP_LOAD,
          opcode == OP_STORE:
            nxt = MEM_ADDR;
          opcode == OP_BRANCH: begin
            if (branch_ok(funct3)) begin
              nxt = BRANCH;
            end else begin
              trap_ill = 1'b1;
              nxt      = TRAP;
            end
          end
          opcode == OP_LUI:
            nxt = LUI;
          opcode == OP_AUIPC:
            nxt = AUIPC;
          opcode == OP_JAL:
            nxt = JAL;
          default: begin
            trap_ill = 1'b1;
            nxt      = TRAP;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_op    = ALU_FUNCT;
        nxt       = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
        nxt       = WB_ALU;
      end
      LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        nxt       = WB_ALU;
      end
      AUIPC: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        nxt       = WB_ALU;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_ALU;
        retire     = 1'b1;
        nxt        = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        nxt = (opcode == OP_LOAD) ? MEM_RD
                                  : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        waiting  = 1'b1;
        if (mem_ready) begin
          nxt = WB_MEM;
        end else if (expired) begin
          trap_to = 1'b1;
          nxt     = TRAP;
        end
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        retire     = 1'b1;
        nxt        = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        waiting   = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = FETCH;
        end else if (expired) begin
          trap_to = 1'b1;
          nxt     = TRAP;
        end
      end
      BRANCH: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_op    = ALU_SUB;
        pc_source = 1'b1;
        pc_write  = zero ^ funct3[0];
        retire    = 1'b1;
        nxt       = FETCH;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_source  = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = M2R_PC;
        retire     = 1'b1;
        nxt        = FETCH;
      end
      TRAP: begin
        nxt = TRAP;
      end
      default: begin
        nxt = FETCH;
      end
    endcase
    if (!RESET_N) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = M2R_ALU;
      alu_src_a  = A_PC;
      alu_src_b  = B_RS2;
      alu_op     = ALU_ADD;
      pc_source  = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Cycle-by-cycle vector bench for the
// multicycle controller, scoreboard checked.
module tb_control_multiciclo;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, mem_read;
  logic        mem_write, iord, reg_write;
  logic [1:0]  mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        pc_source, illegal, timeout;
  logic [31:0] retired;

  always #5 CLK = ~CLK;

  control_multiciclo #(
    .TIMEOUT(4),
    .CNT_W  (32)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .opcode    (opcode),
    .funct3    (funct3),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .iord      (iord),
    .reg_write (reg_write),
    .mem_to_reg(mem_to_reg),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_source (pc_source),
    .illegal   (illegal),
    .timeout   (timeout),
    .retired   (retired)
  );

  // {pcw,irw,mr,mw,iord,rw},m2r,a,b,aop,pcs
  localparam logic [14:0] F_R =
    {6'b111000, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0};
  localparam logic [14:0] F_W =
    {6'b001000, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0};
  localparam logic [14:0] DEC =
    {6'b000000, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0};
  localparam logic [14:0] EXR =
    {6'b000000, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0};
  localparam logic [14:0] EXI =
    {6'b000000, 2'd0, 2'd1, 2'd2, 2'd2, 1'b0};
  localparam logic [14:0] WBA =
    {6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [14:0] MAD =
    {6'b000000, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0};
  localparam logic [14:0] MRD =
    {6'b001010, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [14:0] WBM =
    {6'b000001, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [14:0] MWR =
    {6'b000110, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [14:0] BR1 =
    {6'b100000, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1};
  localparam logic [14:0] BR0 =
    {6'b000000, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1};
  localparam logic [14:0] JL =
    {6'b100001, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1};
  localparam logic [14:0] LU =
    {6'b000000, 2'd0, 2'd3, 2'd2, 2'd0, 1'b0};
  localparam logic [14:0] AU =
    {6'b000000, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0};
  localparam logic [14:0] NON = 15'd0;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] LU_OP = 7'b0110111;
  localparam logic [6:0] AU_OP = 7'b0010111;
  localparam logic [6:0] JL_OP = 7'b1101111;

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [14:0] ctl;
    logic        ill;
    logic        to;
    logic [31:0] ret;
  } row_t;

  typedef struct {
    int          idx;
    logic [14:0] ctl;
    logic        ill;
    logic        to;
    logic [31:0] ret;
  } exp_t;

  row_t rows[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [14:0] act;
  assign act = {pc_write, ir_write, mem_read,
                mem_write, iord, reg_write,
                mem_to_reg, alu_src_a,
                alu_src_b, alu_op, pc_source};

  function automatic void add(
    input logic        rst_n,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        z,
    input logic        rdy,
    input logic [14:0] ctl,
    input logic        ill,
    input logic        to,
    input logic [31:0] ret
  );
    row_t r;
    r.rst_n = rst_n; r.op = op; r.f3 = f3;
    r.z = z; r.rdy = rdy; r.ctl = ctl;
    r.ill = ill; r.to = to; r.ret = ret;
    rows.push_back(r);
  endfunction

  function automatic void rst_rows(input int n);
    for (int i = 0; i < n; i++)
      add(0, 7'd0, 3'd0, 0, 0, NON, 0, 0, 0);
  endfunction

  function automatic void alu_instr(
    input logic [6:0]  op,
    input logic [14:0] ex,
    input logic [31:0] r
  );
    add(1, op, 3'd0, 0, 1, F_R, 0, 0, r);
    add(1, op, 3'd0, 0, 1, DEC, 0, 0, r);
    add(1, op, 3'd0, 0, 1, ex, 0, 0, r);
    add(1, op, 3'd0, 0, 1, WBA, 0, 0, r);
  endfunction

  function automatic void br_instr(
    input logic [2:0]  f3,
    input logic        z,
    input logic [14:0] br,
    input logic [31:0] r
  );
    add(1, BR_OP, f3, z, 1, F_R, 0, 0, r);
    add(1, BR_OP, f3, z, 1, DEC, 0, 0, r);
    add(1, BR_OP, f3, z, 1, br, 0, 0, r);
  endfunction

  task automatic step(input row_t r, input int idx);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET_N   = r.rst_n;
    opcode    = r.op;
    funct3    = r.f3;
    zero      = r.z;
    mem_ready = r.rdy;
    e.idx = idx; e.ctl = r.ctl; e.ill = r.ill;
    e.to = r.to; e.ret = r.ret;
    exp_q.push_back(e);
  endtask

  // scoreboard: compare each driven cycle
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e.ctl || illegal !== e.ill ||
          timeout !== e.to) begin
        errors++;
        $display("FAIL row%0d ctl act=%h/%b%b exp=%h/%b%b",
                 e.idx, act, illegal, timeout,
                 e.ctl, e.ill, e.to);
      end
      checks++;
      if (retired !== e.ret) begin
        errors++;
        $display("FAIL row%0d retired act=%0d exp=%0d",
                 e.idx, retired, e.ret);
      end
    end
  end

  initial begin
    rst_rows(2);
    alu_instr(R_OP, EXR, 0);
    alu_instr(I_OP, EXI, 1);
    add(1, LD_OP, 3'd2, 0, 1, F_R, 0, 0, 2);
    add(1, LD_OP, 3'd2, 0, 1, DEC, 0, 0, 2);
    add(1, LD_OP, 3'd2, 0, 1, MAD, 0, 0, 2);
    for (int i = 0; i < 3; i++)
      add(1, LD_OP, 3'd2, 0, 0, MRD, 0, 0, 2);
    add(1, LD_OP, 3'd2, 0, 1, MRD, 0, 0, 2);
    add(1, LD_OP, 3'd2, 0, 1, WBM, 0, 0, 2);
    add(1, ST_OP, 3'd2, 0, 1, F_R, 0, 0, 3);
    add(1, ST_OP, 3'd2, 0, 1, DEC, 0, 0, 3);
    add(1, ST_OP, 3'd2, 0, 1, MAD, 0, 0, 3);
    add(1, ST_OP, 3'd2, 0, 1, MWR, 0, 0, 3);
    br_instr(3'd0, 1, BR1, 4);
    br_instr(3'd1, 1, BR0, 5);
    br_instr(3'd1, 0, BR1, 6);
    br_instr(3'd0, 0, BR0, 7);
    add(1, JL_OP, 3'd0, 0, 1, F_R, 0, 0, 8);
    add(1, JL_OP, 3'd0, 0, 1, DEC, 0, 0, 8);
    add(1, JL_OP, 3'd0, 0, 1, JL, 0, 0, 8);
    alu_instr(LU_OP, LU, 9);
    alu_instr(AU_OP, AU, 10);
    for (int i = 0; i < 3; i++)
      add(1, R_OP, 3'd0, 0, 0, F_W, 0, 0, 11);
    alu_instr(R_OP, EXR, 11);
    for (int i = 0; i < 4; i++)
      add(1, R_OP, 3'd0, 0, 0, F_W, 0, 0, 12);
    for (int i = 0; i < 5; i++)
      add(1, R_OP, 3'd0, 0, 1, NON, 0, 1, 12);
    rst_rows(1);
    add(1, LD_OP, 3'd2, 0, 1, F_R, 0, 0, 0);
    add(1, LD_OP, 3'd2, 0, 1, DEC, 0, 0, 0);
    add(1, LD_OP, 3'd2, 0, 1, MAD, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, LD_OP, 3'd2, 0, 0, MRD, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      add(1, LD_OP, 3'd2, 0, 1, NON, 0, 1, 0);
    rst_rows(1);
    alu_instr(R_OP, EXR, 0);
    add(1, 7'd0, 3'd0, 0, 1, F_R, 0, 0, 1);
    add(1, 7'd0, 3'd0, 0, 1, DEC, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      add(1, 7'd0, 3'd0, 0, 1, NON, 1, 0, 1);
    rst_rows(1);
    add(1, BR_OP, 3'd4, 1, 1, F_R, 0, 0, 0);
    add(1, BR_OP, 3'd4, 1, 1, DEC, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, BR_OP, 3'd4, 1, 1, NON, 1, 0, 0);
    rst_rows(1);
    alu_instr(R_OP, EXR, 0);
    add(1, ST_OP, 3'd2, 0, 1, F_R, 0, 0, 1);
    add(1, ST_OP, 3'd2, 0, 1, DEC, 0, 0, 1);
    add(1, ST_OP, 3'd2, 0, 1, MAD, 0, 0, 1);
    add(1, ST_OP, 3'd2, 0, 0, MWR, 0, 0, 1);
    add(0, ST_OP, 3'd2, 0, 0, NON, 0, 0, 0);
    add(1, R_OP, 3'd0, 0, 0, F_W, 0, 0, 0);
    alu_instr(R_OP, EXR, 0);
    add(1, R_OP, 3'd0, 0, 1, F_R, 0, 0, 1);

    foreach (rows[i]) step(rows[i], i);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
